// File: rtl/sim_ctrl_monitor.sv
// Simulation controller: holds the cores in reset, runs them, and collects per-hart
// pass/fail/exit results into a sticky final status with an optional cycle timeout.
module sim_ctrl_monitor #(
  parameter int unsigned NUM_HARTS         = 1,
  parameter int unsigned RESET_WAIT_CYCLES = 4,
  parameter int unsigned CNT_WIDTH         = 32,
  parameter int unsigned ABORT_ON_FAIL     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CNT_WIDTH-1:0]    max_cycles_i,
  input  logic [NUM_HARTS-1:0]    tests_passed_i,
  input  logic [NUM_HARTS-1:0]    tests_failed_i,
  input  logic [NUM_HARTS-1:0]    exit_valid_i,
  input  logic [32*NUM_HARTS-1:0] exit_value_i,
  output logic                    core_rst_no,
  output logic                    fetch_enable_o,
  output logic [CNT_WIDTH-1:0]    cycle_cnt_o,
  output logic                    done_o,
  output logic [1:0]              status_o,
  output logic [31:0]             exit_code_o,
  output logic [NUM_HARTS-1:0]    hart_done_o
);

  localparam int unsigned HoldW = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_WAIT_CYCLES - 1);

  localparam logic [1:0] StatusRun     = 2'b00;
  localparam logic [1:0] StatusPass    = 2'b01;
  localparam logic [1:0] StatusFail    = 2'b10;
  localparam logic [1:0] StatusTimeout = 2'b11;

  typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [CNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic                   core_rst_q, core_rst_d;
  logic                   fetch_en_q, fetch_en_d;
  logic                   done_q, done_d;
  logic [1:0]             status_q, status_d;
  logic [31:0]            exit_code_q, exit_code_d;
  logic [NUM_HARTS-1:0]   hart_done_q, hart_done_d;
  logic                   any_fail_q, any_fail_d;

  logic [NUM_HARTS-1:0]   hart_ev;
  logic [NUM_HARTS-1:0]   hart_fail;
  logic [31:0]            fail_code;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = done_q;
    status_d    = status_q;
    exit_code_d = exit_code_q;
    hart_done_d = hart_done_q;
    any_fail_d  = any_fail_q;
    hart_ev     = '0;
    hart_fail   = '0;
    fail_code   = '0;

    for (int h = 0; h < int'(NUM_HARTS); h++) begin
      hart_ev[h]   = (tests_passed_i[h] | tests_failed_i[h] | exit_valid_i[h]) & ~hart_done_q[h];
      hart_fail[h] = hart_ev[h] &
                     (tests_failed_i[h] | (exit_valid_i[h] & (exit_value_i[32*h +: 32] != 32'd0)));
    end
    // Descending scan so the lowest failing index provides the code.
    for (int h = int'(NUM_HARTS) - 1; h >= 0; h--) begin
      if (hart_fail[h]) begin
        fail_code = (exit_valid_i[h] && (exit_value_i[32*h +: 32] != 32'd0)) ?
                    exit_value_i[32*h +: 32] : 32'd1;
      end
    end

    unique case (state_q)
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StRun: begin
        hart_done_d = hart_done_q | hart_ev;
        any_fail_d  = any_fail_q | (|hart_fail);
        if (!any_fail_q && (|hart_fail)) begin
          exit_code_d = fail_code;
        end
        // Completion beats timeout when both occur on the same edge.
        if ((&hart_done_d) || ((ABORT_ON_FAIL != 0) && (|hart_fail))) begin
          state_d  = StDone;
          done_d   = 1'b1;
          status_d = any_fail_d ? StatusFail : StatusPass;
        end else if ((max_cycles_i != '0) && (cycle_cnt_q >= max_cycles_i)) begin
          state_d  = StDone;
          done_d   = 1'b1;
          status_d = StatusTimeout;
        end else if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
        end
      end
      StDone: begin
      end
      default: begin
        state_d = StHold;
      end
    endcase

    core_rst_d = (state_d != StHold);
    fetch_en_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      core_rst_q  <= 1'b0;
      fetch_en_q  <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= StatusRun;
      exit_code_q <= '0;
      hart_done_q <= '0;
      any_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      core_rst_q  <= core_rst_d;
      fetch_en_q  <= fetch_en_d;
      done_q      <= done_d;
      status_q    <= status_d;
      exit_code_q <= exit_code_d;
      hart_done_q <= hart_done_d;
      any_fail_q  <= any_fail_d;
    end
  end

  assign core_rst_no    = core_rst_q;
  assign fetch_enable_o = fetch_en_q;
  assign cycle_cnt_o    = cycle_cnt_q;
  assign done_o         = done_q;
  assign status_o       = status_q;
  assign exit_code_o    = exit_code_q;
  assign hart_done_o    = hart_done_q;

endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// Bench for sim_ctrl_monitor: three differently configured instances share one stimulus
// stream and are checked every cycle against a result-level model plus literal pins.
module tb_sim_ctrl_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] max_a;
  logic [3:0]  max_b;
  logic [3:0]  tp, tf, te;
  logic [31:0] tv [4];
  logic [127:0] tval;

  always #5 clk = ~clk;
  assign tval = {tv[3], tv[2], tv[1], tv[0]};

  logic        d_rst [3];
  logic        d_fe  [3];
  logic        d_done[3];
  logic [1:0]  d_st  [3];
  logic [31:0] d_code[3];
  logic [31:0] d_cnt0, d_cnt1;
  logic [3:0]  d_cnt2;
  logic [0:0]  d_hd0;
  logic [3:0]  d_hd1, d_hd2;

  sim_ctrl_monitor #(.NUM_HARTS(1), .RESET_WAIT_CYCLES(4), .CNT_WIDTH(32), .ABORT_ON_FAIL(1))
  u_dut0 (
    .clk(clk), .rst_n(rst_n), .max_cycles_i(max_a),
    .tests_passed_i(tp[0:0]), .tests_failed_i(tf[0:0]), .exit_valid_i(te[0:0]),
    .exit_value_i(tv[0]),
    .core_rst_no(d_rst[0]), .fetch_enable_o(d_fe[0]), .cycle_cnt_o(d_cnt0),
    .done_o(d_done[0]), .status_o(d_st[0]), .exit_code_o(d_code[0]), .hart_done_o(d_hd0)
  );

  sim_ctrl_monitor #(.NUM_HARTS(4), .RESET_WAIT_CYCLES(4), .CNT_WIDTH(32), .ABORT_ON_FAIL(0))
  u_dut1 (
    .clk(clk), .rst_n(rst_n), .max_cycles_i(max_a),
    .tests_passed_i(tp), .tests_failed_i(tf), .exit_valid_i(te), .exit_value_i(tval),
    .core_rst_no(d_rst[1]), .fetch_enable_o(d_fe[1]), .cycle_cnt_o(d_cnt1),
    .done_o(d_done[1]), .status_o(d_st[1]), .exit_code_o(d_code[1]), .hart_done_o(d_hd1)
  );

  sim_ctrl_monitor #(.NUM_HARTS(4), .RESET_WAIT_CYCLES(2), .CNT_WIDTH(4), .ABORT_ON_FAIL(1))
  u_dut2 (
    .clk(clk), .rst_n(rst_n), .max_cycles_i(max_b),
    .tests_passed_i(tp), .tests_failed_i(tf), .exit_valid_i(te), .exit_value_i(tval),
    .core_rst_no(d_rst[2]), .fetch_enable_o(d_fe[2]), .cycle_cnt_o(d_cnt2),
    .done_o(d_done[2]), .status_o(d_st[2]), .exit_code_o(d_code[2]), .hart_done_o(d_hd2)
  );

  // Instance configuration as seen by the model.
  int unsigned c_nh [3] = '{1, 4, 4};
  int unsigned c_rwc[3] = '{4, 4, 2};
  int unsigned c_cw [3] = '{32, 32, 4};
  int unsigned c_ab [3] = '{1, 0, 1};

  // Model: edges since reset release, sticky result and per-hart bookkeeping.
  int unsigned       m_rel    [3];
  bit                m_done   [3];
  logic [1:0]        m_status [3];
  logic [31:0]       m_code   [3];
  logic [3:0]        m_hdone  [3];
  bit                m_anyfail[3];
  longint unsigned   m_cnt    [3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] at %0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_rel[k]     = 0;
    m_done[k]    = 1'b0;
    m_status[k]  = 2'b00;
    m_code[k]    = 32'd0;
    m_hdone[k]   = 4'd0;
    m_anyfail[k] = 1'b0;
    m_cnt[k]     = 0;
  endtask

  task automatic model_update(input int k);
    bit              in_run, fail_now, all_done;
    longint unsigned mx, lim;
    logic [3:0]      mask;
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    in_run = (m_rel[k] >= c_rwc[k]) && !m_done[k];
    if (m_rel[k] < 1000) m_rel[k]++;
    if (!in_run) return;
    fail_now = 1'b0;
    for (int h = 0; h < int'(c_nh[k]); h++) begin
      if (!m_hdone[k][h] && (tp[h] || tf[h] || te[h])) begin
        m_hdone[k][h] = 1'b1;
        if (tf[h] || (te[h] && tv[h] != 32'd0)) begin
          fail_now = 1'b1;
          if (!m_anyfail[k]) begin
            m_anyfail[k] = 1'b1;
            m_code[k]    = (te[h] && tv[h] != 32'd0) ? tv[h] : 32'd1;
          end
        end
      end
    end
    mask     = 4'((1 << c_nh[k]) - 1);
    all_done = ((m_hdone[k] & mask) == mask);
    mx       = (k < 2) ? longint'(max_a) : longint'(max_b);
    lim      = (64'd1 << c_cw[k]) - 64'd1;
    if (all_done || (c_ab[k] != 0 && fail_now)) begin
      m_done[k]   = 1'b1;
      m_status[k] = m_anyfail[k] ? 2'b10 : 2'b01;
    end else if (mx != 0 && m_cnt[k] >= mx) begin
      m_done[k]   = 1'b1;
      m_status[k] = 2'b11;
    end else if (m_cnt[k] < lim) begin
      m_cnt[k]++;
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int k);
    return (k == 0) ? d_cnt0 : (k == 1) ? d_cnt1 : {28'd0, d_cnt2};
  endfunction

  function automatic logic [31:0] dut_hd(input int k);
    return (k == 0) ? {31'd0, d_hd0} : (k == 1) ? {28'd0, d_hd1} : {28'd0, d_hd2};
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check("core_rst_no", k, 32'(d_rst[k]), 32'(m_rel[k] >= c_rwc[k]));
      check("fetch_enable_o", k, 32'(d_fe[k]), 32'((m_rel[k] >= c_rwc[k]) && !m_done[k]));
      check("cycle_cnt_o", k, dut_cnt(k), 32'(m_cnt[k]));
      check("done_o", k, 32'(d_done[k]), 32'(m_done[k]));
      check("status_o", k, 32'(d_st[k]), 32'(m_status[k]));
      check("exit_code_o", k, d_code[k], m_code[k]);
      check("hart_done_o", k, dut_hd(k), 32'(m_hdone[k]));
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_in();
    tp = 4'd0; tf = 4'd0; te = 4'd0;
    for (int h = 0; h < 4; h++) tv[h] = 32'd0;
  endtask

  task automatic idle(input int n);
    clear_in();
    repeat (n) step();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) model_reset(k);
    #1;
    compare_all();
  endtask

  initial begin
    clear_in();
    max_a = 32'd0;
    max_b = 4'd0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) model_reset(k);
    @(negedge clk);
    compare_all();
    step();

    // Hold length and single-hart clean exit.
    rst_n = 1'b1;
    idle(3);
    check("pin_hold3_rst", 0, 32'(d_rst[0]), 32'd0);
    step();
    check("pin_hold4_rst", 0, 32'(d_rst[0]), 32'd1);
    check("pin_hold4_fe", 0, 32'(d_fe[0]), 32'd1);
    idle(10);
    check("pin_cnt10", 0, d_cnt0, 32'd10);
    te = 4'b0001; tv[0] = 32'd0;
    step();
    check("pin_exit0_done", 0, 32'(d_done[0]), 32'd1);
    check("pin_exit0_status", 0, 32'(d_st[0]), 32'd1);
    check("pin_exit0_code", 0, d_code[0], 32'd0);
    check("pin_exit0_cnt", 0, d_cnt0, 32'd10);
    idle(10);
    check("pin_sat15", 2, {28'd0, d_cnt2}, 32'd15);
    check("pin_sat_notdone", 2, 32'(d_done[2]), 32'd0);

    // Remaining harts finish, hart3 with exit code 7.
    tp = 4'b0010;
    step();
    idle(1);
    tp = 4'b0100; te = 4'b1000; tv[3] = 32'd7;
    step();
    check("pin_all_status", 1, 32'(d_st[1]), 32'd2);
    check("pin_all_code", 1, d_code[1], 32'd7);
    check("pin_all_hd", 1, {28'd0, d_hd1}, 32'hF);
    check("pin_all_rst", 1, 32'(d_rst[1]), 32'd1);
    check("pin_all_fe", 1, 32'(d_fe[1]), 32'd0);
    check("pin_abort_code", 2, d_code[2], 32'd7);
    tf = 4'hF; te = 4'hF;
    for (int h = 0; h < 4; h++) tv[h] = 32'd3;
    step();
    check("pin_sticky_code", 1, d_code[1], 32'd7);
    idle(2);

    // Reset in DONE; two harts fail in the same cycle.
    assert_reset();
    check("pin_rst_done", 1, 32'(d_done[1]), 32'd0);
    check("pin_rst_hd", 1, {28'd0, d_hd1}, 32'd0);
    step();
    rst_n = 1'b1;
    idle(4);
    te = 4'b1010; tv[1] = 32'd5; tv[3] = 32'd9;
    step();
    check("pin_dual_status", 2, 32'(d_st[2]), 32'd2);
    check("pin_dual_code", 2, d_code[2], 32'd5);
    check("pin_dual_hd", 2, {28'd0, d_hd2}, 32'b1010);
    check("pin_dual_noabort", 1, 32'(d_done[1]), 32'd0);
    idle(2);

    // Timeout, and completion on the timeout cycle.
    assert_reset();
    max_a = 32'd20;
    max_b = 4'd9;
    step();
    rst_n = 1'b1;
    idle(24);
    check("pin_to_cnt20", 0, d_cnt0, 32'd20);
    check("pin_to_small_status", 2, 32'(d_st[2]), 32'd3);
    check("pin_to_small_cnt", 2, {28'd0, d_cnt2}, 32'd9);
    tp = 4'b0001;
    step();
    check("pin_to_pass_wins", 0, 32'(d_st[0]), 32'd1);
    check("pin_to_timeout", 1, 32'(d_st[1]), 32'd3);
    check("pin_to_cnt_hold", 1, d_cnt1, 32'd20);
    idle(2);

    // Failed wins over passed; failure without exit_valid gives code 1; reset mid-run.
    assert_reset();
    max_a = 32'd0;
    max_b = 4'd0;
    step();
    rst_n = 1'b1;
    idle(6);
    tp = 4'b0100; tf = 4'b0100;
    step();
    check("pin_fw_status", 2, 32'(d_st[2]), 32'd2);
    check("pin_fw_code", 2, d_code[2], 32'd1);
    check("pin_fw_code_noabort", 1, d_code[1], 32'd1);
    idle(3);
    assert_reset();
    check("pin_midrun_code", 1, d_code[1], 32'd0);
    check("pin_midrun_cnt", 0, d_cnt0, 32'd0);
    step();
    rst_n = 1'b1;
    idle(3);
    check("pin_rehold_rst", 0, 32'(d_rst[0]), 32'd0);
    step();
    check("pin_rerun_rst", 0, 32'(d_rst[0]), 32'd1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
